// File: rtl/instr_sequencer_pkg.sv
// Shared types for the instruction sequencer that feeds the 8-bit core.
// Function codes, instruction field offsets and FSM states.
package instr_sequencer_pkg;

  typedef enum logic [1:0] {
    FUN_MVI = 2'd0,
    FUN_MV  = 2'd1,
    FUN_ADD = 2'd2,
    FUN_SUB = 2'd3
  } fun_e;

  // field offsets above the N-bit immediate
  localparam int FUN_OFS = 4;
  localparam int RX_OFS  = 2;
  localparam int RY_OFS  = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    WAIT  = 2'd3
  } state_e;

endpackage

// File: rtl/instr_sequencer_seq_prog_mem.sv
// Program buffer: synchronous write, registered read.
// The read register doubles as the issued-instruction register.
module seq_prog_mem #(
  parameter int N     = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N+5:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [N+5:0]  rdata
);

  logic [N+5:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_sequencer.sv
// Issues buffered micro-instructions to the core one at a time,
// waiting for Done between them, with a per-instruction timeout.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int N       = 8,
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [N+5:0]  prog_wdata,
  input  logic          start,
  input  logic [AW:0]   len,
  input  logic          Done,
  input  logic [N-1:0]  BusWires,
  output logic [N-1:0]  Data,
  output logic [1:0]    Fun,
  output logic [1:0]    Rx,
  output logic [1:0]    Ry,
  output logic          Run,
  output logic          busy,
  output logic          seq_done,
  output logic          timeout_err,
  output logic [AW-1:0] pc,
  output logic [N-1:0]  last_bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_e         state;
  state_e         state_nx;
  logic [AW:0]    len_q;
  logic [TW-1:0]  timer;
  logic [N+5:0]   instr;
  logic           go;
  logic           go0;
  logic           fetch;
  logic           hit;
  logic           abort;
  logic           last;
  logic           expire;
  logic           wr;

  assign last   = ({1'b0, pc} == len_q - (AW+1)'(1));
  assign expire = (timer == TW'(TIMEOUT - 1));
  assign wr     = prog_we & ~busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (go) state_nx = FETCH;
      FETCH: state_nx = ISSUE;
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (hit) state_nx = last ? IDLE : FETCH;
        else if (abort) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    Run   = 1'b0;
    busy  = 1'b1;
    fetch = 1'b0;
    go    = 1'b0;
    go0   = 1'b0;
    hit   = 1'b0;
    abort = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        go   = start && (len != '0);
        go0  = start && (len == '0);
      end
      FETCH: fetch = 1'b1;
      ISSUE: Run = 1'b1;
      WAIT: begin
        hit   = Done;
        abort = !Done && expire;
      end
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q       <= '0;
      pc          <= '0;
      timer       <= '0;
      seq_done    <= 1'b0;
      timeout_err <= 1'b0;
      last_bus    <= '0;
    end else begin
      seq_done <= (hit && last) || go0;
      if (go || go0) timeout_err <= 1'b0;
      else if (abort) timeout_err <= 1'b1;
      if (go) begin
        // a count beyond the buffer is clamped so pc never wraps
        len_q <= (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;
        pc    <= '0;
      end else if (hit && !last) begin
        pc <= pc + AW'(1);
      end
      if (Run) timer <= '0;
      else if (state == WAIT && !Done) timer <= timer + TW'(1);
      if (hit) last_bus <= BusWires;
    end
  end

  seq_prog_mem #(
    .N     (N),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .rst_n (reset),
    .we    (wr),
    .waddr (prog_addr),
    .wdata (prog_wdata),
    .re    (fetch),
    .raddr (pc),
    .rdata (instr)
  );

  assign Data = instr[N-1:0];
  assign Fun  = instr[N+FUN_OFS +: 2];
  assign Rx   = instr[N+RX_OFS +: 2];
  assign Ry   = instr[N+RY_OFS +: 2];

endmodule
